uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one uart_byte_tx among N byte requesters. It latches the winning requester's byte and drives data_byte/send_en into the transmitter. It waits for Tx_Done, acknowledges the requester, then enforces an inter-byte idle gap. A watchdog aborts a byte that never completes. It sits between the application byte sources and the single Rs232_Tx serializer.

Parameters:
N, 4, number of requesters (2..8)
GAP_CYCLES, 16, idle clock cycles enforced after each byte before the next grant (0 allowed = no gap state dwell)
TIMEOUT, 65535, max cycles from send_en to Tx_Done before abort; counter width = clog2(TIMEOUT+1)

Ports:
Clk  input  1  system clock, all logic on rising edge
Rst_n  input  1  synchronous active-low reset
req  input  N  per-requester level request; held high until its req_ack
req_data  input  8*N  packed bytes, requester i at bits [8i+7:8i]; stable while req[i] high
req_ack  output  N  one-cycle one-hot pulse: byte of requester i transmitted
grant  output  N  one-hot owner of transmitter, 0 when idle/gap
data_byte  output  8  byte to uart_byte_tx
send_en  output  1  one-cycle start pulse to uart_byte_tx
Tx_Done  input  1  one-cycle completion pulse from uart_byte_tx
uart_state  input  1  transmitter busy flag from uart_byte_tx
busy  output  1  high in any state except IDLE
timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (Rst_n low at a rising edge): state=IDLE; req_ack=0, grant=0, data_byte=8'h00, send_en=0, busy=0, timeout_err=0; counters=0; last-served pointer=N-1 (requester 0 has top priority first). Reset overrides everything, including mid-WAIT; the transmitter is not aborted but its later Tx_Done is ignored in IDLE.
- States: IDLE, LAUNCH, WAIT, GAP.
- IDLE: if req!=0, pick first set bit searching upward from (pointer+1) mod N with wrap. At the same edge: grant=one-hot winner, data_byte=req_data slice, pointer=winner -> LAUNCH. Tx_Done in IDLE is ignored.
- LAUNCH: if uart_state==0, send_en=1 for exactly one cycle, clear watchdog -> WAIT. Otherwise hold in LAUNCH with send_en=0. Latency: req seen at edge k -> grant after k -> send_en high after k+1 (when uart_state is low).
- WAIT: watchdog increments each cycle.
  - Tx_Done=1: req_ack[winner]=1 for one cycle, grant=0 -> GAP.
  - Watchdog reaches TIMEOUT without Tx_Done: timeout_err=1 for one cycle, no ack, grant=0 -> GAP. Tx_Done wins if both occur in the same cycle.
- GAP: count GAP_CYCLES cycles -> IDLE. GAP_CYCLES=0 means one cycle in GAP. req is ignored during GAP.
- data_byte holds its last value outside LAUNCH/WAIT. The grant snapshot is used even if req_data changes later.
- If req[i] drops after grant, the byte still completes and req_ack[i] still pulses.
- Requester owning ack must deassert req in the ack cycle or it re-enters arbitration. Round robin still lets others go first.
- Pointer updates at grant, so a timed-out requester loses priority.
- busy=1 from the grant edge through the last GAP cycle.

Test Plan:
- After reset, req=4'b0001, req_data[7:0]=8'hAA, baud_set=4 -> grant=0001 and data_byte=AA one cycle later; single send_en pulse next cycle; req_ack=0001 pulse one cycle after Tx_Done; Rs232_Tx shows AA; busy drops GAP_CYCLES+1 cycles after ack.
- req=4'b1111 simultaneously, data 11/22/33/44 -> bytes sent in order 11,22,33,44; each ack one-hot in order 0,1,2,3; each send_en separated by >= GAP_CYCLES idle cycles after the preceding Tx_Done.
- req0 and req2 held high continuously (re-asserted after ack), data 55/66 -> grants alternate 0001,0100,0001,0100; neither is served twice in a row.
- uart_state forced high for 40 cycles after grant -> send_en stays 0 in LAUNCH, then pulses exactly once on the cycle after uart_state falls.
- TIMEOUT=100, Tx_Done stubbed low -> timeout_err pulses 100 cycles after send_en; no req_ack; with req=0011 the next grant goes to requester 1.
- Rst_n pulled low for 1 cycle mid-WAIT -> all outputs 0 on the next edge; a late Tx_Done produces no ack; the first grant afterwards goes to requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_byte_tx among N byte requesters.
// Latches the winner's byte, launches it, waits for Tx_Done (with a
// watchdog), acknowledges the requester and then holds an idle gap.
module uart_tx_arbiter #(
    parameter int N          = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   req_ack,
    output logic [N-1:0]   grant,
    output logic [7:0]     data_byte,
    output logic           send_en,
    input  logic           Tx_Done,
    input  logic           uart_state,
    output logic           busy,
    output logic           timeout_err
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic [TW-1:0] wd_cnt;
    logic [GW-1:0] gap_cnt;
    logic [PW-1:0] pick;
    logic          pick_vld;
    logic [7:0]    req_bytes [N];

    // Unpack the per-requester byte lanes so the winner can index them directly
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign req_bytes[i] = req_data[8*i +: 8];
    end

    // Round-robin search: nearest set request above the last-served pointer.
    // Iterating from the far end lets the closest candidate overwrite the rest.
    always_comb begin
        pick     = ptr;
        pick_vld = 1'b0;
        for (int off = N; off >= 1; off--) begin
            if (req[PW'((int'(ptr) + off) % N)]) begin
                pick     = PW'((int'(ptr) + off) % N);
                pick_vld = 1'b1;
            end
        end
    end

    // Scheduler FSM; req_ack, send_en and timeout_err are single-cycle pulses
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state       <= S_IDLE;
            ptr         <= PW'(N - 1);
            grant       <= '0;
            req_ack     <= '0;
            data_byte   <= 8'h00;
            send_en     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
        end else begin
            send_en     <= 1'b0;
            req_ack     <= '0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Tx_Done here belongs to an aborted/reset transfer: ignored
                    if (pick_vld) begin
                        grant     <= ONE << pick;
                        data_byte <= req_bytes[pick];
                        ptr       <= pick;
                        busy      <= 1'b1;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (!uart_state) begin
                        send_en <= 1'b1;
                        wd_cnt  <= '0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (Tx_Done) begin
                        req_ack <= grant;
                        grant   <= '0;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else if (wd_cnt == TW'(TIMEOUT - 1)) begin
                        // Abort lands exactly TIMEOUT cycles after send_en
                        timeout_err <= 1'b1;
                        grant       <= '0;
                        gap_cnt     <= '0;
                        state       <= S_GAP;
                    end
                end
                S_GAP: begin
                    // GAP_CYCLES+1 cycles of dwell; requests are not sampled
                    if (gap_cnt == GW'(GAP_CYCLES)) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural transmitter stub.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int GAP = 4;
    localparam int TO  = 100;

    logic            Clk;
    logic            Rst_n;
    logic [NR-1:0]   req;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_ack;
    logic [NR-1:0]   grant;
    logic [7:0]      data_byte;
    logic            send_en;
    logic            Tx_Done;
    logic            uart_state;
    logic            busy;
    logic            timeout_err;

    typedef struct {
        logic [NR-1:0] g;
        logic [7:0]    d;
    } exp_t;

    exp_t          exp_q [$];
    logic [NR-1:0] ack_q [$];
    exp_t          e_pop;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_send = 0;
    int n_to = 0;
    int send_cyc = 0;
    int end_cyc = 0;
    bit end_vld = 0;
    bit prev_send = 0;
    bit prev_busy = 0;

    logic [NR-1:0] req_set;
    int            max_srv [NR];
    int            ack_cnt [NR];
    int            tx_cnt = 0;
    int            tx_lat = 8;
    bit            tx_hang = 0;
    bit            tx_active = 0;
    bit            force_busy = 0;

    uart_tx_arbiter #(.N(NR), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .req        (req),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .grant      (grant),
        .data_byte  (data_byte),
        .send_en    (send_en),
        .Tx_Done    (Tx_Done),
        .uart_state (uart_state),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    assign uart_state = force_busy || tx_active;

    // A requester drops its line in the ack cycle once it has been served max_srv times
    always_comb begin
        for (int i = 0; i < NR; i++) req[i] = req_set[i] && (ack_cnt[i] < max_srv[i]);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, expv, $time);
        end
    endtask

    task automatic push_exp(input int idx, input logic [7:0] d, input bit ack);
        exp_t e;
        e.g = 4'b0001 << idx;
        e.d = d;
        exp_q.push_back(e);
        if (ack) ack_q.push_back(4'b0001 << idx);
    endtask

    task automatic do_reset();
        Rst_n   = 1'b0;
        req_set = '0;
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_grant", grant, 0);
        chk("rst_ack", req_ack, 0);
        chk("rst_data", data_byte, 0);
        chk("rst_send", send_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_to", timeout_err, 0);
        Rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while ((busy || exp_q.size() != 0 || ack_q.size() != 0 || req != 0) && n < 3000);
        chk("idle_reached", (n < 3000), 1);
    endtask

    // Transmitter stub, scoreboard pop and timing monitors
    always @(negedge Clk) begin
        Tx_Done = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) Tx_Done = 1'b1;
        end
        if (!Rst_n) end_vld = 0;
        if (send_en) begin
            chk("send_width", prev_send, 0);
            chk("send_forced", force_busy, 0);
            if (end_vld) chk("gap_space", ((cyc - end_cyc) >= GAP + 1), 1);
            if (exp_q.size() == 0) chk("send_unexp", send_en, 0);
            else begin
                e_pop = exp_q.pop_front();
                chk("grant", grant, e_pop.g);
                chk("data", data_byte, e_pop.d);
            end
            send_cyc = cyc;
            n_send++;
            if (!tx_hang) tx_cnt = tx_lat;
        end
        prev_send = send_en;
        tx_active = (tx_cnt > 0);
        for (int i = 0; i < NR; i++) begin
            if (!req_set[i]) ack_cnt[i] = 0;
            else if (req_ack[i]) ack_cnt[i]++;
        end
        if (req_ack != 0) begin
            if (ack_q.size() == 0) chk("ack_unexp", req_ack, 0);
            else chk("ack", req_ack, ack_q.pop_front());
            chk("ack_grant", grant, 0);
            end_cyc = cyc;
            end_vld = 1;
        end
        if (timeout_err) begin
            chk("to_lat", cyc - send_cyc, TO);
            chk("to_ack", req_ack, 0);
            n_to++;
            end_cyc = cyc;
            end_vld = 1;
        end
        if (prev_busy && !busy && end_vld && Rst_n) chk("busy_gap", cyc - end_cyc, GAP + 1);
        prev_busy = busy;
    end

    initial begin
        int sends_before;
        int n;
        Rst_n    = 1'b0;
        req_set  = '0;
        req_data = '0;
        for (int i = 0; i < NR; i++) max_srv[i] = 1;

        // single byte, latency of grant and send_en
        do_reset();
        req_data = {8'h00, 8'h00, 8'h00, 8'hAA};
        push_exp(0, 8'hAA, 1);
        req_set = 4'b0001;
        @(negedge Clk);
        chk("t1_grant", grant, 4'b0001);
        chk("t1_data", data_byte, 8'hAA);
        chk("t1_busy", busy, 1);
        chk("t1_send_early", send_en, 0);
        @(negedge Clk);
        chk("t1_send", send_en, 1);
        wait_idle();

        // all four at once: served 0,1,2,3
        do_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < NR; i++) push_exp(i, req_data[8*i +: 8], 1);
        req_set = 4'b1111;
        wait_idle();

        // requesters 0 and 2 keep requesting: strict alternation
        do_reset();
        req_data = {8'h00, 8'h66, 8'h00, 8'h55};
        max_srv[0] = 3;
        max_srv[2] = 3;
        for (int k = 0; k < 3; k++) begin
            push_exp(0, 8'h55, 1);
            push_exp(2, 8'h66, 1);
        end
        req_set = 4'b0101;
        wait_idle();
        max_srv[0] = 1;
        max_srv[2] = 1;

        // transmitter busy holds the launch
        do_reset();
        force_busy = 1;
        req_data = {8'h00, 8'h00, 8'h77, 8'h00};
        push_exp(1, 8'h77, 1);
        sends_before = n_send;
        req_set = 4'b0010;
        repeat (40) @(negedge Clk);
        chk("force_hold", n_send - sends_before, 0);
        chk("force_grant", grant, 4'b0010);
        force_busy = 0;
        @(negedge Clk);
        chk("force_send", send_en, 1);
        wait_idle();
        chk("force_once", n_send - sends_before, 1);

        // watchdog abort, then requester 1 ahead of the timed-out requester 0
        do_reset();
        tx_hang  = 1;
        req_data = {8'h00, 8'h00, 8'h5B, 8'h5A};
        push_exp(0, 8'h5A, 0);
        push_exp(1, 8'h5B, 1);
        push_exp(0, 8'h5A, 1);
        req_set = 4'b0011;
        n = 0;
        while (n_to == 0 && n < 400) begin
            @(negedge Clk);
            n++;
        end
        chk("to_seen", n_to, 1);
        tx_hang = 0;
        wait_idle();

        // reset in the middle of WAIT: late Tx_Done must not ack
        do_reset();
        tx_lat   = 30;
        req_data = {8'h00, 8'h99, 8'h00, 8'h00};
        push_exp(2, 8'h99, 0);
        sends_before = n_send;
        req_set = 4'b0100;
        n = 0;
        while (n_send == sends_before && n < 50) begin
            @(negedge Clk);
            n++;
        end
        chk("mid_send", n_send - sends_before, 1);
        repeat (5) @(negedge Clk);
        Rst_n   = 1'b0;
        req_set = '0;
        @(negedge Clk);
        chk("mid_grant", grant, 0);
        chk("mid_busy", busy, 0);
        chk("mid_data", data_byte, 0);
        chk("mid_send0", send_en, 0);
        Rst_n = 1'b1;
        repeat (40) @(negedge Clk);
        chk("late_busy", busy, 0);
        chk("late_ack", req_ack, 0);
        tx_lat   = 8;
        req_data = {8'h00, 8'hC2, 8'h00, 8'hC0};
        push_exp(0, 8'hC0, 1);
        push_exp(2, 8'hC2, 1);
        req_set = 4'b0101;
        @(negedge Clk);
        chk("post_rst_grant", grant, 4'b0001);
        wait_idle();

        chk("total_sends", n_send, 18);
        chk("total_timeouts", n_to, 1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench stalled");
    end

endmodule
